// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes, FSM states and op classification helpers
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLLI   = 5'd3,
        OP_SLT    = 5'd4,
        OP_SLTU   = 5'd5,
        OP_XOR    = 5'd6,
        OP_SRL    = 5'd7,
        OP_SRA    = 5'd8,
        OP_SRLI   = 5'd9,
        OP_SRAI   = 5'd10,
        OP_OR     = 5'd11,
        OP_AND    = 5'd12,
        OP_MUL    = 5'd13,
        OP_MULH   = 5'd14,
        OP_MULHSU = 5'd15,
        OP_MULHU  = 5'd16,
        OP_DIV    = 5'd17,
        OP_DIVU   = 5'd18,
        OP_REM    = 5'd19,
        OP_REMU   = 5'd20
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= 5'(OP_MUL)) && (op <= 5'(OP_REMU));
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= 5'(OP_DIV)) && (op <= 5'(OP_REMU));
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [CW-1:0]   cnt;
    alu_op_e         op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;

    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_start;

    always_comb begin
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        case (alu_op_e'(op_i))
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        sa    = a_signed & a_i[XLEN-1];
        sb    = b_signed & b_i[XLEN-1];
        a_mag = sa ? -a_i : a_i;
        b_mag = sb ? -b_i : b_i;
        // Division by zero keeps the all-ones quotient, so it is never negated
        case (alu_op_e'(op_i))
            OP_MULH, OP_MULHSU: neg_start = sa ^ sb;
            OP_DIV:             neg_start = (sa ^ sb) && (b_i != '0);
            OP_REM:             neg_start = sa;
            default:            neg_start = 1'b0;
        endcase
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   shifted;
    logic            geq;
    logic [XLEN-1:0] rem_sub;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN-1:0] neg_hi;

    // hi:lo is the product (mul) or remainder:dividend-quotient (div)
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        geq     = shifted >= {1'b0, opnd};
        rem_sub = shifted[XLEN-1:0] - opnd;
        if (is_div(op_q)) begin
            step_hi = geq ? rem_sub : shifted[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], geq};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Upper half of the negated 2*XLEN product without forming the full negation
    assign neg_hi = ~step_hi + XLEN'(step_lo == '0);

    always_comb begin
        case (op_q)
            OP_MUL:             result_o = step_lo;
            OP_MULH, OP_MULHSU: result_o = neg_q ? neg_hi : step_hi;
            OP_MULHU:           result_o = step_hi;
            OP_DIV, OP_DIVU:    result_o = neg_q ? -step_lo : step_lo;
            OP_REM, OP_REMU:    result_o = neg_q ? -step_hi : step_hi;
            default:            result_o = step_lo;
        endcase
    end

    assign done_o = busy && (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_ADD;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
        end else if (kill_i) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start_i) begin
            busy  <= 1'b1;
            cnt   <= '0;
            op_q  <= alu_op_e'(op_i);
            neg_q <= neg_start;
            hi    <= '0;
            lo    <= a_mag;
            opnd  <= b_mag;
        end else if (busy) begin
            hi <= step_hi;
            lo <= step_lo;
            if (done_o) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_muldiv_alu.sv
// rtl/seq_muldiv_alu.sv - single-cycle ALU with iterative mul/div behind a valid/ready handshake
module seq_muldiv_alu
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [2:0]      flags_o
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    fsm_state_e      state;
    logic            accept;
    logic            fast_path;
    logic            div_by_zero;
    logic            signed_ovf;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] quick_res;
    logic            ge_s;
    logic            ge_u;
    logic            ge_s_q;
    logic            ge_u_q;
    logic            iter_start;
    logic            iter_done;
    logic [XLEN-1:0] iter_result;

    assign ready_o = (state == ST_IDLE) || ((state == ST_DONE) && ready_i);
    assign accept  = valid_i && ready_o && !flush_i;

    assign shamt       = src_b_i[SW-1:0];
    assign ge_s        = $signed(src_a_i) >= $signed(src_b_i);
    assign ge_u        = src_a_i >= src_b_i;
    assign div_by_zero = (src_b_i == '0);
    assign signed_ovf  = (src_a_i == MIN_VAL) && (src_b_i == '1) &&
                         ((op_i == 5'(OP_DIV)) || (op_i == 5'(OP_REM)));

    // Corner-case divides bypass the iterator when FAST_DIV0 is set
    assign fast_path  = !is_muldiv(op_i) ||
                        (FAST_DIV0 && is_div(op_i) && (div_by_zero || signed_ovf));
    assign iter_start = accept && !fast_path;

    always_comb begin
        quick_res = src_a_i + src_b_i;
        case (alu_op_e'(op_i))
            OP_SUB:           quick_res = src_a_i - src_b_i;
            OP_SLL, OP_SLLI:  quick_res = src_a_i << shamt;
            OP_SLT:           quick_res = {{(XLEN-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
            OP_SLTU:          quick_res = {{(XLEN-1){1'b0}}, src_a_i < src_b_i};
            OP_XOR:           quick_res = src_a_i ^ src_b_i;
            OP_SRL, OP_SRLI:  quick_res = src_a_i >> shamt;
            OP_SRA, OP_SRAI:  quick_res = $signed(src_a_i) >>> shamt;
            OP_OR:            quick_res = src_a_i | src_b_i;
            OP_AND:           quick_res = src_a_i & src_b_i;
            OP_DIV:           quick_res = div_by_zero ? '1 : MIN_VAL;
            OP_DIVU:          quick_res = '1;
            OP_REM:           quick_res = div_by_zero ? src_a_i : '0;
            OP_REMU:          quick_res = src_a_i;
            default:          quick_res = src_a_i + src_b_i;
        endcase
    end

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv_iter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (iter_start),
        .kill_i   (flush_i),
        .op_i     (op_i),
        .a_i      (src_a_i),
        .b_i      (src_b_i),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            valid_o  <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
            ge_s_q   <= 1'b0;
            ge_u_q   <= 1'b0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (iter_done) begin
                        state    <= ST_DONE;
                        valid_o  <= 1'b1;
                        result_o <= iter_result;
                        flags_o  <= {iter_result == '0, ge_s_q, ge_u_q};
                    end
                end
                default: begin
                    if (accept && fast_path) begin
                        state    <= ST_DONE;
                        valid_o  <= 1'b1;
                        result_o <= quick_res;
                        flags_o  <= {quick_res == '0, ge_s, ge_u};
                    end else if (accept) begin
                        state   <= ST_BUSY;
                        valid_o <= 1'b0;
                        ge_s_q  <= ge_s;
                        ge_u_q  <= ge_u;
                    end else if ((state == ST_DONE) && ready_i) begin
                        state   <= ST_IDLE;
                        valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/seq_muldiv_alu.md
SEQ_MULDIV_ALU -- requirements
Module: seq_muldiv_alu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 8..64, power of two.
REQ-002 Parameter FAST_DIV0, default 1: 1 means divide-by-zero and signed overflow complete in 1 cycle; 0 means they run the full iterative latency.
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 Port valid_i, input, 1: operation request present.
REQ-006 Port ready_o, output, 1: block can accept a request this cycle.
REQ-007 Port op_i, input, 5: operation code, values from alu_pkg::alu_op_e.
REQ-008 Port src_a_i and src_b_i, input, XLEN each: operands A and B.
REQ-009 Port flush_i, input, 1: abort any in-flight operation.
REQ-010 Port valid_o, output, 1: result available.
REQ-011 Port ready_i, input, 1: consumer accepts the result.
REQ-012 Port result_o, output, XLEN: registered result.
REQ-013 Port flags_o, output, 3: registered {zero, ge_signed, ge_unsigned} of the accepted operands; zero refers to result_o.

Function
REQ-014 Ops 0-12 SHALL be: ADD, SUB, SLL, SLLI, SLT, SLTU, XOR, SRL, SRA, SRLI, SRAI, OR, AND.
- Shift amount is src_b_i[log2(XLEN)-1:0] for both register and immediate forms.
REQ-015 Ops 13-20 SHALL be: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with RISC-V M-extension semantics at width XLEN.
REQ-016 Undefined op codes SHALL execute as ADD.
REQ-017 A request SHALL be accepted on a rising edge where valid_i=1, ready_o=1 and flush_i=0.
REQ-018 FSM states SHALL be IDLE, BUSY and DONE.
- ready_o=1 only in IDLE, or in DONE when ready_i=1 (back-to-back).
REQ-019 Ops 0-12 SHALL go IDLE->DONE; valid_o is high on the cycle after acceptance (latency 1).
REQ-020 Ops 13-20 SHALL go IDLE->BUSY.
- BUSY runs exactly XLEN cycles: one shift-add multiply bit, or one restoring-divide bit, per cycle.
- Then BUSY->DONE; valid_o rises XLEN+1 edges after acceptance.
REQ-021 Signed mul/div SHALL operate on magnitudes and apply sign correction in the final BUSY cycle, with no extra latency.
REQ-022 Divide by zero SHALL give: quotient all-ones; remainder = src_a_i.
REQ-023 Signed overflow (DIV of min by -1) SHALL give: quotient = min; remainder = 0.
REQ-024 When FAST_DIV0=1, the cases in REQ-022/023 SHALL complete with latency 1.
REQ-025 In DONE, result_o, flags_o and valid_o SHALL hold stable until ready_i=1.
- On that edge: DONE->IDLE, or DONE->DONE/BUSY if a new request is accepted the same cycle.
REQ-026 flush_i=1 SHALL return the FSM to IDLE on the next edge from any state, with valid_o=0 and no request accepted on that edge.
- flush_i has priority over valid_i and ready_i.
REQ-027 Inputs op_i, src_a_i and src_b_i SHALL be captured at acceptance; later changes have no effect on the in-flight operation.

Reset
REQ-028 While rst_ni=0 the block SHALL hold: FSM=IDLE, valid_o=0, ready_o=1, result_o=0, flags_o=0, iteration counter=0.
REQ-029 Reset asserted mid-BUSY SHALL discard the operation; no valid_o follows deassertion.

Structure
REQ-030 alu_pkg SHALL hold: alu_op_e (5-bit enum), fsm_state_e, and the helper function is_muldiv(op).
REQ-031 The iterative datapath SHALL be the sub-module muldiv_iter.
- Interface: start/op/operands in, done/result out, plus a kill input driven by flush_i.
- The single-cycle ops stay in the top module.

Verification
REQ-032 XLEN=32: ADD 0x7FFFFFFF+1 -> result 0x80000000, zero=0, latency 1, flags {0,1,1}.
REQ-033 MULH 0x80000000 x 0x80000000 -> result 0x40000000 with valid_o on the 33rd edge after acceptance; MULHU 0xFFFFFFFF x 2 -> 0x00000001.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; with FAST_DIV0=1 each has latency 1.
REQ-035 Backpressure: hold ready_i=0 for 5 cycles in DONE -> result_o and valid_o stable throughout; then ready_i=1 with a new ADD valid_i -> accepted on the same edge, and the new result appears next cycle.
REQ-036 Flush on BUSY cycle 10 of a DIV -> IDLE next edge, valid_o never asserts; a following SUB 5-7 -> 0xFFFFFFFE.
REQ-037 rst_ni pulled low mid-MUL (asynchronously, between edges) -> valid_o=0 immediately; after release, ready_o=1 and no stale result appears.
